pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 16-bit five-stage pipeline. It holds its own EX/MEM/WB writer scoreboard. Each cycle it produces the EX-stage operand forwarding selects, the PC/IF-ID hold, the ID/EX bubble, and the flush strobes for a taken redirect. It sits beside the ID and EX stages and supports a configurable register count and a configurable load-use penalty. It also adds flush sequencing and register-target jump interlocks.

## Interface
- NREG, 16, architectural register count (power of two, ≥2)
- AW, $clog2(NREG), register address width
- LD_STALL, 1, stall cycles inserted per load-use hazard (1..3)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  AW  ID source register addresses
- id_use_rs1, id_use_rs2  in  1  source is actually read
- id_wen  in  1  ID instruction writes the register file
- id_wreg  in  AW  ID destination address (already muxed, incl. R15 for JAL)
- id_is_load  in  1  ID instruction is a load
- id_jr  in  1  ID instruction takes its target from rs2 unforwarded (JR/EXEC)
- redirect  in  1  taken branch/jump, valid in the EX/MEM register this cycle
- fwd_a, fwd_b  out  2  EX operand select: 0 = regfile, 1 = WB data, 2 = MEM ALU result
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_bubble  out  1  load a NOP into ID/EX
- flush_ifid, flush_idex  out  1  squash IF/ID and ID/EX contents

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {valid, wen, wreg, load}, and the EX entry also holds rs1/rs2 plus their use bits.
- Every clock: WB ← MEM and MEM ← EX.
- EX ← the ID fields when the instruction advances normally. EX ← all-zero (bubble) when idex_bubble or flush_idex is set, or when id_valid = 0.
- A writer is "live" when valid & wen, and it "hits" a source when its wreg equals that source and the source's use bit is set.
- Forwarding (combinational, for the EX entry):
  - MEM hit with MEM.load = 0 selects 2.
  - Otherwise a WB hit selects 1.
  - Otherwise 0.
  - MEM has priority over WB. A load in MEM is never forwarded from MEM.
- Load-use: the ID source hits a live EX load.
  - Assert pc_stall, ifid_stall and idex_bubble this cycle.
  - Load the stall counter with LD_STALL-1.
  - While the counter is nonzero, all three stay asserted and the counter decrements.
- JR interlock: id_jr and a live writer in EX, MEM or WB hits id_rs2. Stall exactly as for load-use, held for as long as the condition persists (no counter).
- Redirect priority: redirect overrides every stall.
  - flush_ifid = flush_idex = 1.
  - pc_stall = ifid_stall = 0.
  - The stall counter is cleared.
  - EX ← bubble.
  - MEM/WB shift normally, so older instructions complete.
- Outputs combine state and ID inputs. With id_valid = 0, no stall is generated from ID.

## Timing
- Reset (async): all scoreboard entries invalid, stall counter 0. All outputs 0 while rst is high.
- Forward selects are valid in the same cycle the instruction occupies EX. There is zero latency from the scoreboard flops.
- Load-use penalty is exactly LD_STALL bubbles: the consumer enters EX LD_STALL+1 cycles after the load, and takes fwd = 1 when the load is in WB. If LD_STALL ≥ 2 and the load has already retired, fwd = 0.
- A redirect strobe lasts exactly the cycles redirect is high. There is no added latency.
- Reset mid-stall: the counter clears immediately, and the first cycle after reset deassertion has no stall.

## Configuration
- HAZARD_R0_ZERO_EN defined: register 0 is hardwired zero. A source or destination equal to 0 never hits, so it never forwards, never stalls, and never triggers a JR interlock.
- Not defined: register 0 is an ordinary register and is compared like any other.

## Test plan
- ADD R3 in EX→MEM, SUB reading R3 in EX next cycle -> fwd_a = 2; one cycle later an unrelated consumer of R3 -> fwd_a = 1.
- LW R4 then ADD R5,R4,R1 with LD_STALL = 1 -> one cycle of pc_stall/ifid_stall/idex_bubble, then ADD in EX with fwd_a = 1. With LD_STALL = 3 -> exactly 3 stall cycles, then fwd_a = 0.
- JR R7 in ID while ADD R7 sits in EX -> stall for 3 cycles until R7 leaves WB, then proceed with no stall.
- redirect = 1 during an active load-use stall -> same cycle flush_ifid = flush_idex = 1, pc_stall = 0, counter cleared; next cycle EX invalid.
- ADDI R0 followed by a reader of R0: with HAZARD_R0_ZERO_EN -> fwd = 0 and no stall; without it -> fwd = 2.
- Assert rst asynchronously while the counter = 2 -> all outputs 0 immediately, and no stall after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: EX/MEM/WB writer scoreboard driving forwarding, load-use/JR stalls and redirect flushes.
// Optional HAZARD_R0_ZERO_EN: register 0 is hardwired zero and never hits.
module pipe_hazard_ctrl #(
  parameter int NREG     = 16,
  parameter int AW       = $clog2(NREG),
  parameter int LD_STALL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic          id_wen,
  input  logic [AW-1:0] id_wreg,
  input  logic          id_is_load,
  input  logic          id_jr,
  input  logic          redirect,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          idex_bubble,
  output logic          flush_ifid,
  output logic          flush_idex
);
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] wreg;
  } wr_t;
  wr_t           id_w, ex_w, mem_w, wb_w;
  logic          ex_load, mem_load, ex_use1, ex_use2;
  logic [AW-1:0] ex_rs1, ex_rs2;
  logic [1:0]    cnt_q, cnt_d;
  logic          lu, jr, stall, bubble;
  function automatic logic hit(input wr_t w, input logic [AW-1:0] src, input logic use_src);
`ifdef HAZARD_R0_ZERO_EN
    return w.valid && w.wen && use_src && w.wreg == src && src != '0;
`else
    return w.valid && w.wen && use_src && w.wreg == src;
`endif
  endfunction
  // a load sitting in MEM has no data yet, so only WB may supply it
  function automatic logic [1:0] fwd_sel(input wr_t m, input logic m_load, input wr_t w,
                                         input logic [AW-1:0] src, input logic use_src);
    return (hit(m, src, use_src) && !m_load) ? 2'd2 : hit(w, src, use_src) ? 2'd1 : 2'd0;
  endfunction
  assign id_w = '{valid: id_valid, wen: id_wen, wreg: id_wreg};
  always_comb begin
    lu          = id_valid && ex_load && (hit(ex_w, id_rs1, id_use_rs1) || hit(ex_w, id_rs2, id_use_rs2));
    jr          = id_valid && id_jr && (hit(ex_w, id_rs2, id_use_rs2) || hit(mem_w, id_rs2, id_use_rs2) ||
                                        hit(wb_w, id_rs2, id_use_rs2));
    stall       = lu || jr || cnt_q != 2'd0;
    bubble      = stall || redirect || !id_valid;
    cnt_d       = redirect ? 2'd0 : lu ? 2'(LD_STALL - 1) : (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
    fwd_a       = rst ? 2'd0 : fwd_sel(mem_w, mem_load, wb_w, ex_rs1, ex_use1);
    fwd_b       = rst ? 2'd0 : fwd_sel(mem_w, mem_load, wb_w, ex_rs2, ex_use2);
    pc_stall    = !rst && stall && !redirect;
    ifid_stall  = !rst && stall && !redirect;
    idex_bubble = !rst && stall && !redirect;
    flush_ifid  = !rst && redirect;
    flush_idex  = !rst && redirect;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_w     <= '0;
      mem_w    <= '0;
      wb_w     <= '0;
      ex_load  <= 1'b0;
      mem_load <= 1'b0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_use1  <= 1'b0;
      ex_use2  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q    <= cnt_d;
      wb_w     <= mem_w;
      mem_w    <= ex_w;
      mem_load <= ex_load;
      ex_w     <= bubble ? '0 : id_w;
      ex_load  <= !bubble && id_is_load;
      ex_rs1   <= bubble ? '0 : id_rs1;
      ex_rs2   <= bubble ? '0 : id_rs2;
      ex_use1  <= !bubble && id_use_rs1;
      ex_use2  <= !bubble && id_use_rs2;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: cycle-program vectors for LD_STALL=1 and LD_STALL=3 instances, checked via an expectation queue.
module tb_pipe_hazard_ctrl;
`ifdef HAZARD_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  typedef struct {
    string      name;
    logic       r, v;
    logic [3:0] rs1;
    logic       u1;
    logic [3:0] rs2;
    logic       u2, w;
    logic [3:0] wr;
    logic       l, j, d;
    logic [8:0] e1, e3;
  } vec_t;
  typedef struct {
    string      name;
    logic [8:0] e1, e3;
  } exp_t;
  logic       clk, rst, id_valid, id_use_rs1, id_use_rs2, id_wen, id_is_load, id_jr, redirect;
  logic [3:0] id_rs1, id_rs2, id_wreg;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic       pc1, if1, bb1, fi1, fe1, pc3, if3, bb3, fi3, fe3;
  logic [8:0] o1, o3;
  vec_t       prog[$];
  exp_t       sb[$];
  exp_t       cur;
  int         errs = 0;
  int         checks = 0;
  pipe_hazard_ctrl #(.NREG(16), .LD_STALL(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .id_jr(id_jr), .redirect(redirect), .fwd_a(fa1), .fwd_b(fb1),
    .pc_stall(pc1), .ifid_stall(if1), .idex_bubble(bb1), .flush_ifid(fi1), .flush_idex(fe1));
  pipe_hazard_ctrl #(.NREG(16), .LD_STALL(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .id_jr(id_jr), .redirect(redirect), .fwd_a(fa3), .fwd_b(fb3),
    .pc_stall(pc3), .ifid_stall(if3), .idex_bubble(bb3), .flush_ifid(fi3), .flush_idex(fe3));
  assign o1 = {fa1, fb1, pc1, if1, bb1, fi1, fe1};
  assign o3 = {fa3, fb3, pc3, if3, bb3, fi3, fe3};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [8:0] x(input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic fl);
    return {fa, fb, st, st, st, fl, fl};
  endfunction
  localparam logic [8:0] Z  = 9'd0;
  localparam logic [8:0] ST = 9'b0000_111_00;
  localparam logic [8:0] FL = 9'b0000_000_11;
  function automatic vec_t mk(input string n, input logic r, input logic v, input logic [3:0] rs1,
                              input logic u1, input logic [3:0] rs2, input logic u2, input logic w,
                              input logic [3:0] wr, input logic l, input logic j, input logic d,
                              input logic [8:0] e1, input logic [8:0] e3);
    vec_t t;
    t.name = n; t.r = r; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.w = w; t.wr = wr; t.l = l; t.j = j; t.d = d; t.e1 = e1; t.e3 = e3;
    return t;
  endfunction
  function automatic vec_t idle(input string n, input logic r, input logic [8:0] e1, input logic [8:0] e3);
    return mk(n, r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e3);
  endfunction
  task automatic chk(input string n, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  task automatic run(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.r; id_valid = v.v; id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    id_wen = v.w; id_wreg = v.wr; id_is_load = v.l; id_jr = v.j; redirect = v.d;
    e.name = v.name; e.e1 = v.e1; e.e3 = v.e3;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.name, "/L1"}, o1, cur.e1);
      chk({cur.name, "/L3"}, o3, cur.e3);
    end
  end
  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_wen = 0; id_wreg = 0; id_is_load = 0; id_jr = 0; redirect = 0;
    prog.push_back(mk("rst_redir", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z, Z));
    prog.push_back(idle("idle0", 0, Z, Z));
    prog.push_back(mk("add_r3", 0, 1, 1, 1, 2, 1, 1, 3, 0, 0, 0, Z, Z));
    prog.push_back(mk("sub_r3", 0, 1, 3, 1, 4, 1, 1, 5, 0, 0, 0, Z, Z));
    prog.push_back(mk("mem_fwd", 0, 1, 6, 1, 3, 1, 1, 6, 0, 0, 0, x(2, 0, 0, 0), x(2, 0, 0, 0)));
    prog.push_back(idle("wb_fwd", 0, x(0, 1, 0, 0), x(0, 1, 0, 0)));
    prog.push_back(mk("add_r3a", 0, 1, 1, 1, 2, 1, 1, 3, 0, 0, 0, Z, Z));
    prog.push_back(mk("add_r3b", 0, 1, 1, 1, 2, 1, 1, 3, 0, 0, 0, Z, Z));
    prog.push_back(mk("rd_r3", 0, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, Z, Z));
    prog.push_back(idle("mem_pri_nouse", 0, x(2, 0, 0, 0), x(2, 0, 0, 0)));
    prog.push_back(idle("drain", 0, Z, Z));
    prog.push_back(mk("lw_r4", 0, 1, 1, 1, 0, 0, 1, 4, 1, 0, 0, Z, Z));
    prog.push_back(mk("lu1", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, ST, ST));
    prog.push_back(mk("lu2", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, Z, ST));
    prog.push_back(mk("lu3", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, x(1, 0, 0, 0), ST));
    prog.push_back(mk("lu4", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, Z, Z));
    prog.push_back(idle("lu_done", 0, Z, Z));
    prog.push_back(idle("rst2", 1, Z, Z));
    prog.push_back(mk("add_r7", 0, 1, 1, 1, 2, 1, 1, 7, 0, 0, 0, Z, Z));
    prog.push_back(mk("jr_ex", 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, ST, ST));
    prog.push_back(mk("jr_mem", 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, ST, ST));
    prog.push_back(mk("jr_wb", 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, ST, ST));
    prog.push_back(mk("jr_go", 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, Z, Z));
    prog.push_back(idle("jr_in_ex", 0, Z, Z));
    prog.push_back(mk("add_r7b", 0, 1, 1, 1, 2, 1, 1, 7, 0, 0, 0, Z, Z));
    prog.push_back(mk("rd_r7_nojr", 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, Z, Z));
    prog.push_back(idle("fwd_r7", 0, x(2, 0, 0, 0), x(2, 0, 0, 0)));
    prog.push_back(idle("rst3", 1, Z, Z));
    prog.push_back(mk("lw_r4b", 0, 1, 1, 1, 0, 0, 1, 4, 1, 0, 0, Z, Z));
    prog.push_back(mk("lu_rd", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, ST, ST));
    prog.push_back(mk("redir", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 1, FL, FL));
    prog.push_back(idle("post_redir", 0, Z, Z));
    prog.push_back(mk("lw_r4c", 0, 1, 1, 1, 0, 0, 1, 4, 1, 0, 0, Z, Z));
    prog.push_back(mk("lu_novalid", 0, 0, 4, 1, 1, 1, 1, 5, 0, 0, 0, Z, Z));
    prog.push_back(idle("rst4", 1, Z, Z));
    prog.push_back(mk("addi_r0", 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, Z, Z));
    prog.push_back(mk("rd_r0", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, Z, Z));
    prog.push_back(idle("fwd_r0", 0, R0Z ? Z : x(2, 2, 0, 0), R0Z ? Z : x(2, 2, 0, 0)));
    prog.push_back(mk("lw_r0", 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, Z, Z));
    prog.push_back(mk("lu_r0", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, R0Z ? Z : ST, R0Z ? Z : ST));
    for (int i = 0; i < prog.size(); i++) run(prog[i]);
    run(idle("h_rst", 1, Z, Z));
    run(mk("h_lw", 0, 1, 1, 1, 0, 0, 1, 4, 1, 0, 0, Z, Z));
    run(mk("h_lu", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, ST, ST));
    run(mk("h_cnt2", 0, 1, 4, 1, 1, 1, 1, 5, 0, 0, 0, Z, ST));
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_rst/L1", o1, Z);
    chk("async_rst/L3", o3, Z);
    #1 rst = 1'b0;
    #1 chk("post_rst/L1", o1, Z);
    chk("post_rst/L3", o3, Z);
    run(idle("h_after", 0, Z, Z));
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
